halt_dump_ctrl: RTL and testbench

//  Downstream of the processor, between data memory and the UART transmitter. When the

---
 rtl/halt_dump_ctrl_if.sv | 34 +++
 rtl/halt_dump_ctrl.sv | 129 ++++++++++++
 tb/tb_halt_dump_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/halt_dump_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : halt_dump_ctrl_if
//  Description : Bundle between the halt dump controller and its neighbours
//                (dm_ram read port, uart_full transmit handshake, status).
//                The master modport is the controller's view.
//  Revision    : 1.0  initial release
// ============================================================================
interface halt_dump_ctrl_if #(
    parameter int DATA_LENGTH = 16,
    parameter int ADDR_LENGTH = 11,
    parameter int BYTE_BITS   = 8
);
    logic                   i_halt;
    logic [DATA_LENGTH-1:0] i_rd_data;
    logic [ADDR_LENGTH-1:0] o_rd_addr;
    logic                   o_rd_en;
    logic [BYTE_BITS-1:0]   o_tx_data;
    logic                   o_tx_start;
    logic                   i_tx_done;
    logic                   o_busy;
    logic                   o_done;

    modport master (
        input  i_halt, i_rd_data, i_tx_done,
        output o_rd_addr, o_rd_en, o_tx_data, o_tx_start, o_busy, o_done
    );

    modport slave (
        output i_halt, i_rd_data, i_tx_done,
        input  o_rd_addr, o_rd_en, o_tx_data, o_tx_start, o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/halt_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : halt_dump_ctrl
//  Description : On processor halt, reads DUMP_WORDS words of dm_ram starting
//                at DUMP_BASE and streams each word to uart_full as two bytes,
//                high byte first. One dump per reset.
//  Revision    : 1.0  initial release
// ============================================================================
module halt_dump_ctrl #(
    parameter int DATA_LENGTH = 16,
    parameter int ADDR_LENGTH = 11,
    parameter int BYTE_BITS   = 8,
    parameter int DUMP_BASE   = 0,
    parameter int DUMP_WORDS  = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    halt_dump_ctrl_if.master      bus
);

    localparam int CNT_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
    localparam logic [CNT_W-1:0]       c_last_word = CNT_W'(DUMP_WORDS - 1);
    localparam logic [CNT_W-1:0]       c_cnt_one   = CNT_W'(1);
    localparam logic [ADDR_LENGTH-1:0] c_addr_one  = ADDR_LENGTH'(1);
    localparam logic [ADDR_LENGTH-1:0] c_base_addr = ADDR_LENGTH'(DUMP_BASE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_LATCH   = 3'd2,
        S_SEND_HI = 3'd3,
        S_WAIT_HI = 3'd4,
        S_SEND_LO = 3'd5,
        S_WAIT_LO = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_word_cnt;
    logic [DATA_LENGTH-1:0] r_word_reg;
    logic [ADDR_LENGTH-1:0] r_rd_addr;
    logic                   r_rd_en;
    logic [BYTE_BITS-1:0]   r_tx_data;
    logic                   r_tx_start;
    logic                   r_busy;
    logic                   r_done;

    // Dump sequencer: every output is a register updated alongside the state,
    // so strobes (rd_en, tx_start) are asserted on entry and cleared by default.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_word_cnt <= '0;
            r_word_reg <= '0;
            r_rd_addr  <= c_base_addr;
            r_rd_en    <= 1'b0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rd_en    <= 1'b0;
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_halt) begin
                        r_state <= S_READ;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    // RAM data is valid now; launch the high byte straight from it
                    r_word_reg <= bus.i_rd_data;
                    r_tx_data  <= bus.i_rd_data[DATA_LENGTH-1 -: BYTE_BITS];
                    r_tx_start <= 1'b1;
                    r_state    <= S_SEND_HI;
                end
                S_SEND_HI: begin
                    r_tx_data <= r_word_reg[DATA_LENGTH-1 -: BYTE_BITS];
                    r_state   <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (bus.i_tx_done) begin
                        r_tx_data  <= r_word_reg[BYTE_BITS-1:0];
                        r_tx_start <= 1'b1;
                        r_state    <= S_SEND_LO;
                    end
                end
                S_SEND_LO: begin
                    r_state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (bus.i_tx_done) begin
                        if (r_word_cnt == c_last_word) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            // Address wraps naturally at 2**ADDR_LENGTH
                            r_word_cnt <= r_word_cnt + c_cnt_one;
                            r_rd_addr  <= r_rd_addr + c_addr_one;
                            r_rd_en    <= 1'b1;
                            r_state    <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_rd_addr  = r_rd_addr;
    assign bus.o_rd_en    = r_rd_en;
    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_tx_start = r_tx_start;
    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_halt_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_halt_dump_ctrl
//  Description : Directed bench for halt_dump_ctrl. Three instances cover the
//                default window, a window that wraps the address space, and a
//                single-word dump; RAM and UART are modelled behaviourally.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_halt_dump_ctrl;

    logic clk;
    logic rst0, rst1, rst2;
    logic done0, done1, done2;
    logic spur0;
    int   cnt0, cnt1, cnt2;
    logic prev0, prev1, prev2;
    int   viol0, viol1, viol2;
    int   dly;
    int   checks, errors;

    logic [15:0] mem [0:2047];
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [7:0]  q2[$];
    logic [10:0] a1[$];

    halt_dump_ctrl_if #(.DATA_LENGTH(16), .ADDR_LENGTH(11), .BYTE_BITS(8)) if0 ();
    halt_dump_ctrl_if #(.DATA_LENGTH(16), .ADDR_LENGTH(11), .BYTE_BITS(8)) if1 ();
    halt_dump_ctrl_if #(.DATA_LENGTH(16), .ADDR_LENGTH(11), .BYTE_BITS(8)) if2 ();

    halt_dump_ctrl #(.DUMP_BASE(0), .DUMP_WORDS(8))
        u0 (.i_clock(clk), .i_reset(rst0), .bus(if0));
    halt_dump_ctrl #(.DUMP_BASE(2046), .DUMP_WORDS(4))
        u1 (.i_clock(clk), .i_reset(rst1), .bus(if1));
    halt_dump_ctrl #(.DUMP_BASE(0), .DUMP_WORDS(1))
        u2 (.i_clock(clk), .i_reset(rst2), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign if0.i_tx_done = done0 | spur0;
    assign if1.i_tx_done = done1;
    assign if2.i_tx_done = done2;

    // Synchronous-read RAM models: data appears the cycle after rd_en
    always @(posedge clk) if (if0.o_rd_en) if0.i_rd_data <= mem[if0.o_rd_addr];
    always @(posedge clk) if (if1.o_rd_en) if1.i_rd_data <= mem[if1.o_rd_addr];
    always @(posedge clk) if (if2.o_rd_en) if2.i_rd_data <= mem[if2.o_rd_addr];

    // UART models: log each started byte, answer with done after dly cycles
    always @(posedge clk) begin
        if (!rst0) begin
            cnt0 <= 0; done0 <= 1'b0;
        end else begin
            done0 <= 1'b0;
            if (cnt0 > 0) begin
                cnt0 <= cnt0 - 1;
                if (cnt0 == 1) done0 <= 1'b1;
            end
            if (if0.o_tx_start) begin
                q0.push_back(if0.o_tx_data);
                if (dly == 0) done0 <= 1'b1; else cnt0 <= dly;
            end
        end
        if (if0.o_tx_start && prev0) viol0++;
        prev0 <= if0.o_tx_start;
    end

    always @(posedge clk) begin
        if (!rst1) begin
            cnt1 <= 0; done1 <= 1'b0;
        end else begin
            done1 <= 1'b0;
            if (cnt1 > 0) begin
                cnt1 <= cnt1 - 1;
                if (cnt1 == 1) done1 <= 1'b1;
            end
            if (if1.o_tx_start) begin
                q1.push_back(if1.o_tx_data);
                if (dly == 0) done1 <= 1'b1; else cnt1 <= dly;
            end
            if (if1.o_rd_en) a1.push_back(if1.o_rd_addr);
        end
        if (if1.o_tx_start && prev1) viol1++;
        prev1 <= if1.o_tx_start;
    end

    always @(posedge clk) begin
        if (!rst2) begin
            cnt2 <= 0; done2 <= 1'b0;
        end else begin
            done2 <= 1'b0;
            if (cnt2 > 0) begin
                cnt2 <= cnt2 - 1;
                if (cnt2 == 1) done2 <= 1'b1;
            end
            if (if2.o_tx_start) begin
                q2.push_back(if2.o_tx_data);
                if (dly == 0) done2 <= 1'b1; else cnt2 <= dly;
            end
        end
        if (if2.o_tx_start && prev2) viol2++;
        prev2 <= if2.o_tx_start;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic done_of(input int k);
        case (k)
            0:       return if0.o_done;
            1:       return if1.o_done;
            default: return if2.o_done;
        endcase
    endfunction

    task automatic wait_done(input int k, input int budget, input string tag);
        int n = 0;
        while (!done_of(k) && n < budget) begin
            step();
            n++;
        end
        chk(tag, {31'd0, done_of(k)}, 32'd1);
    endtask

    task automatic wait_bytes0(input int need, input int budget, input string tag);
        int n = 0;
        while (q0.size() < need && n < budget) begin
            step();
            n++;
        end
        chk(tag, {31'd0, (q0.size() >= need)}, 32'd1);
    endtask

    // Default window: word i is 16'h1100+i, so bytes alternate 11, i
    task automatic check_dump0(input int base, input string tag);
        logic [31:0] obs;
        logic [7:0]  exp;
        chk({tag, "_count"}, q0.size() - base, 32'd16);
        for (int i = 0; i < 16; i++) begin
            obs = (base + i < q0.size()) ? {24'd0, q0[base + i]} : 32'h100;
            exp = (i % 2 == 0) ? 8'h11 : 8'(i / 2);
            chk($sformatf("%s_byte%0d", tag, i), obs, {24'd0, exp});
        end
    endtask

    task automatic reset0();
        rst0 = 1'b0;
        if0.i_halt = 1'b0;
        step();
        step();
        rst0 = 1'b1;
    endtask

    initial begin
        int          base;
        logic [31:0] obs;
        logic [7:0]  exp1 [0:7];

        checks = 0; errors = 0;
        viol0 = 0; viol1 = 0; viol2 = 0;
        dly = 0; spur0 = 1'b0;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        if0.i_halt = 1'b0; if1.i_halt = 1'b0; if2.i_halt = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 8; i++) mem[i] = 16'h1100 + 16'(i);
        mem[2046] = 16'hA1B2;
        mem[2047] = 16'hC3D4;

        // Reset state
        step();
        step();
        chk("rst_addr",  {21'd0, if0.o_rd_addr}, 32'd0);
        chk("rst_rd_en", {31'd0, if0.o_rd_en}, 32'd0);
        chk("rst_data",  {24'd0, if0.o_tx_data}, 32'd0);
        chk("rst_start", {31'd0, if0.o_tx_start}, 32'd0);
        chk("rst_busy",  {31'd0, if0.o_busy}, 32'd0);
        chk("rst_done",  {31'd0, if0.o_done}, 32'd0);
        chk("rst_addr1", {21'd0, if1.o_rd_addr}, 32'd2046);
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        step();

        // Latency with an immediate UART done
        dly = 0;
        base = q0.size();
        if0.i_halt = 1'b1;
        step();
        chk("lat_rd_en_n1", {31'd0, if0.o_rd_en}, 32'd1);
        chk("lat_addr_n1",  {21'd0, if0.o_rd_addr}, 32'd0);
        chk("lat_busy_n1",  {31'd0, if0.o_busy}, 32'd1);
        step();
        chk("lat_rd_en_n2", {31'd0, if0.o_rd_en}, 32'd0);
        chk("lat_start_n2", {31'd0, if0.o_tx_start}, 32'd0);
        step();
        chk("lat_start_n3", {31'd0, if0.o_tx_start}, 32'd1);
        chk("lat_data_n3",  {24'd0, if0.o_tx_data}, 32'h11);
        step();
        chk("lat_start_n4", {31'd0, if0.o_tx_start}, 32'd0);
        chk("lat_hold_n4",  {24'd0, if0.o_tx_data}, 32'h11);
        step();
        chk("lat_start_n5", {31'd0, if0.o_tx_start}, 32'd1);
        chk("lat_data_n5",  {24'd0, if0.o_tx_data}, 32'h00);
        wait_done(0, 400, "lat_done");
        check_dump0(base, "lat");

        // Full dump with a slow UART, halt at cycle 10
        reset0();
        dly = 20;
        base = q0.size();
        for (int i = 0; i < 10; i++) step();
        if0.i_halt = 1'b1;
        wait_done(0, 2000, "t1_done");
        chk("t1_busy", {31'd0, if0.o_busy}, 32'd0);
        check_dump0(base, "t1");
        for (int i = 0; i < 50; i++) step();
        chk("t1_no_extra", q0.size() - base, 32'd16);
        chk("t1_done_held", {31'd0, if0.o_done}, 32'd1);

        // Spurious done pulses in IDLE, READ, LATCH, SEND_HI; halt drops early
        reset0();
        dly = 3;
        base = q0.size();
        if0.i_halt = 1'b1;
        spur0 = 1'b1;
        for (int i = 0; i < 4; i++) step();
        spur0 = 1'b0;
        wait_bytes0(base + 3, 200, "t4_three");
        if0.i_halt = 1'b0;
        wait_done(0, 1000, "t4_done");
        check_dump0(base, "t4");

        // Reset during WAIT_LO of word 3, then restart with halt held
        reset0();
        dly = 5;
        if0.i_halt = 1'b1;
        wait_bytes0(q0.size() + 8, 500, "t5_eight");
        rst0 = 1'b0;
        step();
        chk("t5_addr",  {21'd0, if0.o_rd_addr}, 32'd0);
        chk("t5_rd_en", {31'd0, if0.o_rd_en}, 32'd0);
        chk("t5_data",  {24'd0, if0.o_tx_data}, 32'd0);
        chk("t5_start", {31'd0, if0.o_tx_start}, 32'd0);
        chk("t5_busy",  {31'd0, if0.o_busy}, 32'd0);
        chk("t5_done",  {31'd0, if0.o_done}, 32'd0);
        rst0 = 1'b1;
        base = q0.size();
        wait_done(0, 1000, "t5_redone");
        check_dump0(base, "t5");

        // Window wrapping the top of the address space
        dly = 2;
        if1.i_halt = 1'b1;
        wait_done(1, 500, "t3_done");
        chk("t3_nreads", a1.size(), 32'd4);
        chk("t3_addr0", (a1.size() > 0) ? {21'd0, a1[0]} : 32'hFFFF, 32'd2046);
        chk("t3_addr1", (a1.size() > 1) ? {21'd0, a1[1]} : 32'hFFFF, 32'd2047);
        chk("t3_addr2", (a1.size() > 2) ? {21'd0, a1[2]} : 32'hFFFF, 32'd0);
        chk("t3_addr3", (a1.size() > 3) ? {21'd0, a1[3]} : 32'hFFFF, 32'd1);
        exp1[0] = 8'hA1; exp1[1] = 8'hB2; exp1[2] = 8'hC3; exp1[3] = 8'hD4;
        exp1[4] = 8'h11; exp1[5] = 8'h00; exp1[6] = 8'h11; exp1[7] = 8'h01;
        chk("t3_count", q1.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            obs = (i < q1.size()) ? {24'd0, q1[i]} : 32'h100;
            chk($sformatf("t3_byte%0d", i), obs, {24'd0, exp1[i]});
        end

        // Single-word dump, halt re-pulsed afterwards
        mem[0] = 16'hBEEF;
        dly = 1;
        if2.i_halt = 1'b1;
        wait_done(2, 300, "t6_done");
        chk("t6_count", q2.size(), 32'd2);
        chk("t6_byte0", (q2.size() > 0) ? {24'd0, q2[0]} : 32'h100, 32'hBE);
        chk("t6_byte1", (q2.size() > 1) ? {24'd0, q2[1]} : 32'h100, 32'hEF);
        if2.i_halt = 1'b0;
        step();
        if2.i_halt = 1'b1;
        for (int i = 0; i < 30; i++) step();
        chk("t6_no_more", q2.size(), 32'd2);
        chk("t6_done_held", {31'd0, if2.o_done}, 32'd1);
        chk("t6_busy", {31'd0, if2.o_busy}, 32'd0);

        chk("start_back_to_back", viol0 + viol1 + viol2, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
